// File: rtl/ctrl_pkg.sv
// Controller encoding constants shared by the instruction loader and the main decoder.
// Opcode map, loader mnemonic codes and 32-bit instruction field positions.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b011000;
    localparam logic [5:0] OP_SUBI  = 6'b011001;
    localparam logic [5:0] OP_LW    = 6'b011010;
    localparam logic [5:0] OP_SW    = 6'b011011;
    localparam logic [5:0] OP_BEQ   = 6'b011100;
    localparam logic [5:0] OP_BNE   = 6'b011101;
    localparam logic [5:0] OP_J     = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000111;

    typedef enum logic [3:0] {
        MN_R    = 4'd0,
        MN_ADDI = 4'd1,
        MN_SUBI = 4'd2,
        MN_LW   = 4'd3,
        MN_SW   = 4'd4,
        MN_BEQ  = 4'd5,
        MN_BNE  = 4'd6,
        MN_J    = 4'd7,
        MN_JAL  = 4'd8
    } mnem_t;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational encoder: mnemonic plus operand fields to a 32-bit instruction word.
// Unknown mnemonic codes raise illegal and produce an all-zero word.
module instr_encoder
    import ctrl_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] jaddr,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (mnem)
            4'(MN_R):    word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
            4'(MN_ADDI): word = enc_i(OP_ADDI, rs, rt, imm);
            4'(MN_SUBI): word = enc_i(OP_SUBI, rs, rt, imm);
            4'(MN_LW):   word = enc_i(OP_LW,   rs, rt, imm);
            4'(MN_SW):   word = enc_i(OP_SW,   rs, rt, imm);
            4'(MN_BEQ):  word = enc_i(OP_BEQ,  rs, rt, imm);
            4'(MN_BNE):  word = enc_i(OP_BNE,  rs, rt, imm);
            4'(MN_J):    word = {OP_J,   jaddr};
            4'(MN_JAL):  word = {OP_JAL, jaddr};
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Streams encoded instructions into imem one word per two cycles, holding the CPU
// in reset until the program ends (last instruction or memory full).
module imem_loader
    import ctrl_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic              in_last,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_jaddr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full,
    output logic [ADDR_W:0]   count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_FINAL = ADDR_W'(BASE_ADDR + DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_ill_q, err_ill_d;
    logic              err_full_q, err_full_d;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        transfer;
    logic        at_final;

    instr_encoder u_enc (
        .mnem    (in_mnem),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .funct   (in_funct),
        .imm     (in_imm),
        .jaddr   (in_jaddr),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // start suppresses ready so a handshake is never lost to a simultaneous restart.
    assign in_ready = (state_q == S_ACCEPT) && !start;
    assign transfer = in_valid && in_ready;
    assign at_final = (addr_q == ADDR_FINAL);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        last_d     = last_q;
        count_d    = count_q;
        err_ill_d  = err_ill_q;
        err_full_d = err_full_q;

        case (state_q)
            S_ACCEPT: begin
                if (transfer) begin
                    // An illegal slot still passes through WRITE, just without the strobe.
                    we_d      = !enc_illegal;
                    wdata_d   = enc_illegal ? wdata_q : enc_word;
                    err_ill_d = err_ill_q || enc_illegal;
                    last_d    = in_last;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (we_q) begin
                    count_d = count_q + 1'b1;
                    if (!at_final) begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                state_d = (last_q || (we_q && at_final)) ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                if (in_valid && (count_q == COUNT_FULL)) begin
                    err_full_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Restart from any state; a write in flight has already landed at this edge.
        if (start) begin
            state_d    = S_ACCEPT;
            addr_d     = ADDR_FIRST;
            count_d    = '0;
            err_ill_d  = 1'b0;
            err_full_d = 1'b0;
            we_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= ADDR_FIRST;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            last_q     <= 1'b0;
            count_q    <= '0;
            err_ill_q  <= 1'b0;
            err_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            last_q     <= last_d;
            count_q    <= count_d;
            err_ill_q  <= err_ill_d;
            err_full_q <= err_full_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_hold    = (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign err_illegal = err_ill_q;
    assign err_full    = err_full_q;
    assign count       = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: stimulus pushes expected imem writes, a
// negedge monitor pops and compares every imem_we cycle it observes.
module tb_imem_loader;
    import ctrl_pkg::*;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_mnem = '0;
    logic              in_last = 1'b0;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_rd = '0;
    logic [5:0]        in_funct = '0;
    logic [15:0]       in_imm = '0;
    logic [25:0]       in_jaddr = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err_illegal;
    logic              err_full;
    logic [ADDR_W:0]   count;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_last(in_last),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
        .in_imm(in_imm), .in_jaddr(in_jaddr),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err_illegal(err_illegal),
        .err_full(err_full), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  pass_cnt  = 0;
    int  total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic expect_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = 32'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%08h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("write addr=%0d data=0x%08h (expect addr=%0d data=0x%08h)",
                         imem_addr, imem_wdata, e.addr, e.data);
                chk("wr_addr", 32'(imem_addr), e.addr);
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic set_fields(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                              input logic [25:0] ja, input logic last);
        in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
        in_funct = f; in_imm = imm; in_jaddr = ja; in_last = last;
    endtask

    task automatic send(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                        input logic [25:0] ja, input logic last);
        int n;
        @(negedge clk);
        set_fields(m, rs, rt, rd, f, imm, ja, last);
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL send_timeout: got in_ready=%b expected 1 within 20 cycles", in_ready);
        end else begin
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},       32'(imem_we), 32'd0);
        chk({tag, "_addr"},     32'(imem_addr), 32'd0);
        chk({tag, "_wdata"},    imem_wdata, 32'd0);
        chk({tag, "_ready"},    32'(in_ready), 32'd0);
        chk({tag, "_hold"},     32'(cpu_hold), 32'd1);
        chk({tag, "_done"},     32'(done), 32'd0);
        chk({tag, "_err_ill"},  32'(err_illegal), 32'd0);
        chk({tag, "_err_full"}, 32'(err_full), 32'd0);
        chk({tag, "_count"},    32'(count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk_reset_vals("por");
        #20 reset_n = 1'b1;
        settle();

        // ADDI rs=1 rt=2 imm=5
        pulse_start();
        expect_wr(0, 32'h6022_0005);
        send(4'(MN_ADDI), 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
        settle();
        chk("t2_count", 32'(count), 32'd1);
        chk("t2_hold", 32'(cpu_hold), 32'd1);

        // R then JAL last
        pulse_start();
        chk("t3_count_clr", 32'(count), 32'd0);
        expect_wr(0, 32'h0464_2820);
        expect_wr(1, 32'h1C00_0010);
        send(4'(MN_R), 5'd3, 5'd4, 5'd5, 6'h20, 16'h0, 26'd0, 1'b0);
        send(4'(MN_JAL), 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 1'b1);
        settle();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_hold", 32'(cpu_hold), 32'd0);
        chk("t3_count", 32'(count), 32'd2);
        chk("t3_ready", 32'(in_ready), 32'd0);

        // Illegal mnemonic between two J
        pulse_start();
        chk("t4_done_clr", 32'(done), 32'd0);
        expect_wr(0, 32'h0000_0010);
        expect_wr(1, 32'h0000_0010);
        send(4'(MN_J), 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 1'b0);
        send(4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b0);
        send(4'(MN_J), 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 1'b1);
        settle();
        chk("t4_err_ill", 32'(err_illegal), 32'd1);
        chk("t4_count", 32'(count), 32'd2);
        chk("t4_done", 32'(done), 32'd1);

        // Fill all DEPTH words, then one more
        pulse_start();
        chk("t5_err_ill_clr", 32'(err_illegal), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            expect_wr(i, 32'h6022_0000 | 32'(i));
            send(4'(MN_ADDI), 5'd1, 5'd2, 5'd0, 6'd0, 16'(i), 26'd0, 1'b0);
        end
        settle();
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_count", 32'(count), 32'd4);
        chk("t5_err_full_pre", 32'(err_full), 32'd0);
        @(negedge clk);
        set_fields(4'(MN_ADDI), 5'd1, 5'd2, 5'd0, 6'd0, 16'd9, 26'd0, 1'b0);
        in_valid = 1'b1;
        chk("t5_ready_full", 32'(in_ready), 32'd0);
        settle();
        in_valid = 1'b0;
        chk("t5_err_full", 32'(err_full), 32'd1);
        chk("t5_count_hold", 32'(count), 32'd4);
        chk("t5_done_hold", 32'(done), 32'd1);

        // in_valid held high across a three-instruction program
        pulse_start();
        chk("t6_err_full_clr", 32'(err_full), 32'd0);
        expect_wr(0, 32'h6422_0007);
        expect_wr(1, 32'h6822_0007);
        expect_wr(2, 32'h7022_0007);
        for (int i = 0; i < 3; i++) begin
            int n;
            @(negedge clk);
            case (i)
                0: set_fields(4'(MN_SUBI), 5'd1, 5'd2, 5'd0, 6'd0, 16'd7, 26'd0, 1'b0);
                1: set_fields(4'(MN_LW),   5'd1, 5'd2, 5'd0, 6'd0, 16'd7, 26'd0, 1'b0);
                default: set_fields(4'(MN_BEQ), 5'd1, 5'd2, 5'd0, 6'd0, 16'd7, 26'd0, 1'b1);
            endcase
            in_valid = 1'b1;
            n = 0;
            while (in_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t6_ready_hi", 32'(in_ready), 32'd1);
            @(negedge clk);
            chk("t6_ready_lo", 32'(in_ready), 32'd0);
        end
        settle();
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_count", 32'(count), 32'd3);
        chk("t6_err_full", 32'(err_full), 32'd0);
        set_fields(4'(MN_SW), 5'd1, 5'd2, 5'd0, 6'd0, 16'd7, 26'd0, 1'b1);
        expect_wr(0, 32'h6C22_0007);
        pulse_start();
        settle();
        in_valid = 1'b0;
        chk("t6_restart_count", 32'(count), 32'd1);
        chk("t6_restart_done", 32'(done), 32'd1);
        chk("t6_drain", 32'(exp_q.size()), 32'd0);

        // Reset asserted while a write is in flight
        pulse_start();
        send(4'(MN_ADDI), 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
        chk("t1_we_pre", 32'(imem_we), 32'd1);
        #1 reset_n = 1'b0;
        #1 chk_reset_vals("t1");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t1_idle_ready", 32'(in_ready), 32'd0);
        chk("t1_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
